mem_link_responder: RTL and testbench

- Memory-side endpoint of the serial controller/memory link.
- Receives requests on the c_to_m channel: one address header, then 32-bit data beats for writes.
- Converts each request into a single cache-line transaction on a line-granular back-end port (same line format as banked memory, 256-bit).
- Returns results on the m_to_c channel: a write acknowledge, or a read header followed by LINE_BEATS data beats.

---
 rtl/mem_link_responder.sv | 194 +++++++++++++++++++
 tb/tb_mem_link_responder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_link_responder.sv
// Memory-side link endpoint: turns c_to_m requests into single line transactions
// and returns a write ack or a read header plus LINE_BEATS data beats on m_to_c.
module mem_link_responder #(
  parameter int DATA_W     = 32,
  parameter int LINE_BEATS = 8,
  parameter int OFFSET_W   = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            address_data_bus_c_to_m,
  input  logic                         address_on_c_to_m,
  input  logic                         data_on_c_to_m,
  input  logic                         read_en_c_to_m,
  input  logic                         write_en_c_to_m,
  input  logic                         resp_c_to_m,
  output logic [DATA_W-1:0]            address_data_bus_m_to_c,
  output logic                         address_on_m_to_c,
  output logic                         data_on_m_to_c,
  output logic                         read_en_m_to_c,
  output logic                         write_en_m_to_c,
  output logic                         resp_m_to_c,
  output logic [DATA_W-1:0]            line_addr,
  output logic                         line_read,
  output logic                         line_write,
  output logic [DATA_W*LINE_BEATS-1:0] line_wdata,
  input  logic                         line_ready,
  input  logic [DATA_W*LINE_BEATS-1:0] line_rdata,
  input  logic                         line_rvalid,
  output logic                         busy,
  output logic                         proto_err
);
  // state      | meaning
  // IDLE       | waiting for a request header
  // WR_COLLECT | gathering write beats into the line buffer
  // ISSUE      | line request held until line_ready
  // RD_WAIT    | waiting for line_rvalid
  // RSP_HDR    | read header held until resp_c_to_m
  // RSP_DATA   | streaming read beats, low word first
  // WR_ACK     | write ack held until resp_c_to_m

  localparam int LINE_W = DATA_W * LINE_BEATS;
  localparam int CNT_W  = $clog2(LINE_BEATS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_BEATS - 1);

  typedef enum logic [2:0] {
    IDLE, WR_COLLECT, ISSUE, RD_WAIT, RSP_HDR, RSP_DATA, WR_ACK
  } state_t;

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [DATA_W-1:0]   addr_q, addr_n;
  logic                is_wr_q, is_wr_n;
  logic [LINE_W-1:0]   wdata_q, wdata_n;
  logic [LINE_W-1:0]   rdata_q, rdata_n;
  logic                perr_n;
  logic                hdr_rd, hdr_wr;

  logic [DATA_W-1:0]   bus_n;
  logic                aon_n, don_n, ren_n, wen_n, rsp_n, lrd_n, lwr_n;

  assign hdr_rd = address_on_c_to_m && read_en_c_to_m && !write_en_c_to_m;
  assign hdr_wr = address_on_c_to_m && write_en_c_to_m && !read_en_c_to_m;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    addr_n  = addr_q;
    is_wr_n = is_wr_q;
    wdata_n = wdata_q;
    rdata_n = rdata_q;
    perr_n  = proto_err;
    if (state_q != IDLE && address_on_c_to_m) perr_n = 1'b1;
    case (state_q)
      IDLE: begin
        if (data_on_c_to_m) perr_n = 1'b1;
        if (hdr_rd || hdr_wr) begin
          addr_n  = {address_data_bus_c_to_m[DATA_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          is_wr_n = hdr_wr;
          cnt_n   = '0;
          state_n = hdr_wr ? WR_COLLECT : ISSUE;
        end else if (address_on_c_to_m) begin
          perr_n = 1'b1;
        end
      end
      WR_COLLECT: begin
        if (data_on_c_to_m) begin
          wdata_n[cnt_q*DATA_W +: DATA_W] = address_data_bus_c_to_m;
          cnt_n = cnt_q + 1'b1;
          if (cnt_q == LAST) state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (line_ready) state_n = is_wr_q ? WR_ACK : RD_WAIT;
      end
      RD_WAIT: begin
        if (line_rvalid) begin
          rdata_n = line_rdata;
          state_n = RSP_HDR;
        end
      end
      RSP_HDR: begin
        if (resp_c_to_m) begin
          cnt_n   = '0;
          state_n = RSP_DATA;
        end
      end
      RSP_DATA: begin
        cnt_n = cnt_q + 1'b1;
        if (cnt_q == LAST) state_n = IDLE;
      end
      WR_ACK: begin
        if (resp_c_to_m) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered with no input-to-output path.
  always_comb begin
    bus_n = '0;
    aon_n = 1'b0;
    don_n = 1'b0;
    ren_n = 1'b0;
    wen_n = 1'b0;
    rsp_n = 1'b0;
    lrd_n = 1'b0;
    lwr_n = 1'b0;
    case (state_n)
      ISSUE: begin
        lrd_n = !is_wr_n;
        lwr_n = is_wr_n;
      end
      RSP_HDR: begin
        aon_n = 1'b1;
        ren_n = 1'b1;
        bus_n = addr_n;
      end
      RSP_DATA: begin
        don_n = 1'b1;
        bus_n = rdata_n[cnt_n*DATA_W +: DATA_W];
        rsp_n = (cnt_n == LAST);
      end
      WR_ACK: begin
        aon_n = 1'b1;
        wen_n = 1'b1;
        rsp_n = 1'b1;
        bus_n = addr_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q                 <= IDLE;
      cnt_q                   <= '0;
      addr_q                  <= '0;
      is_wr_q                 <= 1'b0;
      wdata_q                 <= '0;
      rdata_q                 <= '0;
      proto_err               <= 1'b0;
      busy                    <= 1'b0;
      address_data_bus_m_to_c <= '0;
      address_on_m_to_c       <= 1'b0;
      data_on_m_to_c          <= 1'b0;
      read_en_m_to_c          <= 1'b0;
      write_en_m_to_c         <= 1'b0;
      resp_m_to_c             <= 1'b0;
      line_read               <= 1'b0;
      line_write              <= 1'b0;
    end else begin
      state_q                 <= state_n;
      cnt_q                   <= cnt_n;
      addr_q                  <= addr_n;
      is_wr_q                 <= is_wr_n;
      wdata_q                 <= wdata_n;
      rdata_q                 <= rdata_n;
      proto_err               <= perr_n;
      busy                    <= (state_n != IDLE);
      address_data_bus_m_to_c <= bus_n;
      address_on_m_to_c       <= aon_n;
      data_on_m_to_c          <= don_n;
      read_en_m_to_c          <= ren_n;
      write_en_m_to_c         <= wen_n;
      resp_m_to_c             <= rsp_n;
      line_read               <= lrd_n;
      line_write              <= lwr_n;
    end
  end

  assign line_addr  = addr_q;
  assign line_wdata = wdata_q;

endmodule

// File: tb/tb_mem_link_responder.sv
// Bench for mem_link_responder: scripted transaction model predicts every output each cycle,
// plus literal checks on captured traffic for the directed scenarios.
module tb_mem_link_responder;

  typedef struct packed {
    logic [31:0]  bus;
    logic         aon, don, ren, wen, rsp;
    logic [31:0]  laddr;
    logic         lrd, lwr;
    logic [255:0] lwdata;
    logic         busy, perr;
  } outs_t;

  logic         clk, rst;
  logic [31:0]  c_bus;
  logic         c_aon, c_don, c_ren, c_wen, c_resp;
  logic [31:0]  m_bus;
  logic         m_aon, m_don, m_ren, m_wen, m_rsp;
  logic [31:0]  line_addr;
  logic         line_read, line_write, line_ready, line_rvalid;
  logic [255:0] line_wdata, line_rdata;
  logic         busy, proto_err;

  mem_link_responder dut (
    .clk(clk), .rst(rst),
    .address_data_bus_c_to_m(c_bus), .address_on_c_to_m(c_aon), .data_on_c_to_m(c_don),
    .read_en_c_to_m(c_ren), .write_en_c_to_m(c_wen), .resp_c_to_m(c_resp),
    .address_data_bus_m_to_c(m_bus), .address_on_m_to_c(m_aon), .data_on_m_to_c(m_don),
    .read_en_m_to_c(m_ren), .write_en_m_to_c(m_wen), .resp_m_to_c(m_rsp),
    .line_addr(line_addr), .line_read(line_read), .line_write(line_write),
    .line_wdata(line_wdata), .line_ready(line_ready), .line_rdata(line_rdata),
    .line_rvalid(line_rvalid), .busy(busy), .proto_err(proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  outs_t exp_o;
  logic [31:0]  m_laddr = '0;
  logic [255:0] m_wdata = '0;
  logic         m_perr  = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, expv);
    end
  endtask

  function automatic outs_t base(input bit b);
    outs_t o;
    o        = '0;
    o.laddr  = m_laddr;
    o.lwdata = m_wdata;
    o.busy   = b;
    o.perr   = m_perr;
    return o;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  always @(negedge clk) begin
    chk("bus_m_to_c", m_bus, exp_o.bus);
    chk("address_on_m_to_c", m_aon, exp_o.aon);
    chk("data_on_m_to_c", m_don, exp_o.don);
    chk("read_en_m_to_c", m_ren, exp_o.ren);
    chk("write_en_m_to_c", m_wen, exp_o.wen);
    chk("resp_m_to_c", m_rsp, exp_o.rsp);
    chk("line_addr", line_addr, exp_o.laddr);
    chk("line_read", line_read, exp_o.lrd);
    chk("line_write", line_write, exp_o.lwr);
    chk("line_wdata", line_wdata, exp_o.lwdata);
    chk("busy", busy, exp_o.busy);
    chk("proto_err", proto_err, exp_o.perr);
  end

  // Traffic capture for the literal checks.
  logic [31:0]  rd_q[$];
  int           rsp_idx, ack_cycles, lrd_cycles, lwr_cycles, lrd_addr_chg;
  logic [31:0]  hdr_addr, lrd_prev;
  logic [255:0] last_lwdata;

  task automatic mon_clear();
    rd_q.delete();
    rsp_idx = -1; ack_cycles = 0; lrd_cycles = 0; lwr_cycles = 0; lrd_addr_chg = 0;
    hdr_addr = '0; last_lwdata = '0;
  endtask

  always @(negedge clk) begin
    if (m_don) begin
      rd_q.push_back(m_bus);
      if (m_rsp) rsp_idx = rd_q.size() - 1;
    end
    if (m_aon && m_ren) hdr_addr = m_bus;
    if (m_aon && m_wen && m_rsp) ack_cycles++;
    if (line_read) begin
      if (lrd_cycles > 0 && line_addr != lrd_prev) lrd_addr_chg++;
      lrd_prev = line_addr;
      lrd_cycles++;
    end
    if (line_write) begin
      lwr_cycles++;
      last_lwdata = line_wdata;
    end
  end

  task automatic clear_in();
    c_bus = '0; c_aon = 0; c_don = 0; c_ren = 0; c_wen = 0; c_resp = 0;
    line_ready = 0; line_rvalid = 0;
  endtask

  task automatic step(input outs_t nx);
    @(posedge clk);
    #1;
    exp_o = nx;
  endtask

  task automatic apply_reset();
    clear_in();
    rst = 1'b1;
    m_laddr = '0; m_wdata = '0; m_perr = 1'b0;
    #1;
    exp_o = base(0);
    chk("rst_imm_busy", busy, 0);
    chk("rst_imm_line_wdata", line_wdata, 0);
    chk("rst_imm_line_addr", line_addr, 0);
    chk("rst_imm_line_write", line_write, 0);
    step(base(0));
    step(base(0));
    rst = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int rdy_d, input int rv_d, input int rsp_d,
                         input logic [255:0] rd, input bit inject);
    outs_t nx;
    c_aon = 1; c_ren = 1; c_bus = a;
    m_laddr = a & 32'hFFFF_FFE0;
    nx = base(1); nx.lrd = 1; step(nx); clear_in();
    for (int i = 0; i < rdy_d; i++) begin
      nx = base(1); nx.lrd = 1; step(nx);
    end
    line_ready = 1; step(base(1)); line_ready = 0;
    for (int i = 0; i < rv_d; i++) begin
      if (inject && i == 0) begin
        c_aon = 1; c_wen = 1; c_bus = $urandom; m_perr = 1'b1;
      end
      step(base(1)); clear_in();
    end
    line_rvalid = 1; line_rdata = rd;
    nx = base(1); nx.aon = 1; nx.ren = 1; nx.bus = m_laddr; step(nx);
    line_rvalid = 0; line_rdata = rand256();
    for (int i = 0; i < rsp_d; i++) step(nx);
    c_resp = 1;
    nx = base(1); nx.don = 1; nx.bus = rd[31:0]; step(nx);
    c_resp = 0;
    for (int b = 1; b < 8; b++) begin
      nx = base(1); nx.don = 1; nx.bus = rd[32*b +: 32]; nx.rsp = (b == 7); step(nx);
    end
    step(base(0));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [255:0] wd, input logic [7:0] gaps,
                          input int rdy_d, input int rsp_d, input int abort_after);
    outs_t nx;
    c_aon = 1; c_wen = 1; c_bus = a;
    m_laddr = a & 32'hFFFF_FFE0;
    step(base(1)); clear_in();
    for (int b = 0; b < 8; b++) begin
      if (gaps[b]) begin
        c_bus = $urandom; step(base(1)); clear_in();
      end
      c_don = 1; c_bus = wd[32*b +: 32];
      m_wdata[32*b +: 32] = wd[32*b +: 32];
      nx = base(1); nx.lwr = (b == 7); step(nx); clear_in();
      if (b == abort_after) begin
        apply_reset();
        return;
      end
    end
    for (int i = 0; i < rdy_d; i++) begin
      nx = base(1); nx.lwr = 1; step(nx);
    end
    line_ready = 1;
    nx = base(1); nx.aon = 1; nx.wen = 1; nx.rsp = 1; nx.bus = m_laddr; step(nx);
    line_ready = 0;
    for (int i = 0; i < rsp_d; i++) step(nx);
    c_resp = 1; step(base(0)); c_resp = 0;
  endtask

  task automatic idle_err(input int kind);
    case (kind)
      0: begin c_aon = 1; c_ren = 1; c_wen = 1; c_bus = $urandom; end
      1: begin c_aon = 1; c_bus = $urandom; end
      default: begin c_don = 1; c_bus = $urandom; end
    endcase
    m_perr = 1'b1;
    step(base(0)); clear_in();
  endtask

  logic [255:0] rd_v, wd_v;
  int k, rv, abrt;

  initial begin
    rst = 1'b0;
    clear_in();
    line_rdata = '0;
    exp_o = base(0);
    mon_clear();
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_busy", busy, 0);
    chk("reset_proto_err", proto_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(base(0));

    // Directed read, line words 0..7.
    for (int i = 0; i < 8; i++) rd_v[32*i +: 32] = i;
    mon_clear();
    do_read(32'h1ECE_B004, 1, 1, 2, rd_v, 0);
    chk("dir_rd_hdr_addr", hdr_addr, 32'h1ECE_B000);
    chk("dir_rd_beats", rd_q.size(), 8);
    for (int i = 0; i < 8 && i < rd_q.size(); i++) chk("dir_rd_beat", rd_q[i], i);
    chk("dir_rd_resp_last", rsp_idx, 7);

    // Directed write with two gap cycles, ack held three cycles.
    for (int i = 0; i < 8; i++) wd_v[32*i +: 32] = 32'hA0 + i;
    mon_clear();
    do_write(32'h0000_1020, wd_v, 8'b0010_0100, 0, 2, -1);
    chk("dir_wr_low_word", last_lwdata[31:0], 32'hA0);
    chk("dir_wr_high_word", last_lwdata[255:224], 32'hA7);
    chk("dir_wr_ack_cycles", ack_cycles, 3);
    chk("dir_wr_line_write_cycles", lwr_cycles, 1);

    // Back end stalls five cycles.
    mon_clear();
    do_read(32'h0000_2468, 5, 0, 0, rand256(), 0);
    chk("stall_line_read_cycles", lrd_cycles, 6);
    chk("stall_addr_changes", lrd_addr_chg, 0);

    // Protocol errors in IDLE.
    mon_clear();
    idle_err(0);
    chk("err_both_perr", proto_err, 1);
    idle_err(2);
    step(base(0));
    chk("err_busy", busy, 0);
    chk("err_line_activity", lrd_cycles + lwr_cycles, 0);

    // Reset after write beat 3, then a clean read of 0x40.
    do_write(32'h0000_3000, rand256(), 8'h00, 0, 0, 3);
    chk("abort_perr_cleared", proto_err, 0);
    mon_clear();
    do_read(32'h0000_0040, 0, 0, 0, rand256(), 0);
    chk("post_rst_hdr_addr", hdr_addr, 32'h40);
    chk("post_rst_no_write", lwr_cycles, 0);

    // Second header while waiting for read data.
    rd_v = rand256();
    mon_clear();
    do_read(32'hCAFE_0010, 0, 2, 1, rd_v, 1);
    chk("inject_perr", proto_err, 1);
    chk("inject_beats", rd_q.size(), 8);
    for (int i = 0; i < 8 && i < rd_q.size(); i++) chk("inject_beat", rd_q[i], rd_v[32*i +: 32]);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      k = $urandom_range(0, 9);
      if (k < 4) begin
        rv = $urandom_range(0, 3);
        do_read($urandom, $urandom_range(0, 3), rv, $urandom_range(0, 3), rand256(),
                (rv > 0) && ($urandom_range(0, 3) == 0));
      end else if (k < 8) begin
        abrt = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
        do_write($urandom, rand256(), 8'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 3), abrt);
      end else if (k == 8) begin
        idle_err($urandom_range(0, 2));
      end else begin
        step(base(0));
      end
    end
    step(base(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, elapsed %0t want under 2000000", $time);
    $fatal(1);
  end

endmodule
